// File: rtl/pu_stream_ctrl.sv
// Job sequencer for one 8-lane MAC PU: issues K paired buffer reads, steers the
// PU valid/accumulate/done strobes through the read and MAC latencies, then holds the result handshake.
module pu_stream_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LAT     = 1,
  parameter int MAC_LAT    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] k_len_i,
  input  logic [ADDR_WIDTH-1:0] x_base_i,
  input  logic [ADDR_WIDTH-1:0] w_base_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  x_ren_o,
  output logic [ADDR_WIDTH-1:0] x_addr_o,
  output logic                  w_ren_o,
  output logic [ADDR_WIDTH-1:0] w_addr_o,
  output logic                  pu_en_o,
  output logic                  pu_acc_clr_o,
  output logic                  pu_valid_o,
  output logic                  pu_acc_o,
  output logic                  pu_done_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i
);
  localparam int L  = RD_LAT + MAC_LAT;
  localparam int DW = $clog2(L) + 1;

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, LATCH, OUT} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DW-1:0]         dcnt;
  logic [L-1:0]          vld_pipe;

  // One delay line carries read enables: tap RD_LAT gives data-present, tap L gives accumulate.
  assign pu_valid_o = vld_pipe[RD_LAT-1];
  assign pu_acc_o   = vld_pipe[L-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cnt          <= '0;
      dcnt         <= '0;
      vld_pipe     <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      x_ren_o      <= 1'b0;
      w_ren_o      <= 1'b0;
      x_addr_o     <= '0;
      w_addr_o     <= '0;
      pu_en_o      <= 1'b0;
      pu_acc_clr_o <= 1'b0;
      pu_done_o    <= 1'b0;
      out_valid_o  <= 1'b0;
    end else begin
      done_o       <= 1'b0;
      pu_acc_clr_o <= 1'b0;
      pu_done_o    <= 1'b0;
      vld_pipe     <= {vld_pipe[L-2:0], x_ren_o};
      case (state)
        IDLE: begin
          busy_o <= 1'b0;
          if (start_i) begin
            if (k_len_i != '0) begin
              state        <= FETCH;
              busy_o       <= 1'b1;
              pu_en_o      <= 1'b1;
              pu_acc_clr_o <= 1'b1;
              x_ren_o      <= 1'b1;
              w_ren_o      <= 1'b1;
              x_addr_o     <= x_base_i;
              w_addr_o     <= w_base_i;
              cnt          <= k_len_i - ADDR_WIDTH'(1);
            end else begin
              done_o <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (cnt == '0) begin
            x_ren_o <= 1'b0;
            w_ren_o <= 1'b0;
            dcnt    <= DW'(L - 1);
            state   <= DRAIN;
          end else begin
            x_addr_o <= x_addr_o + 1'b1;
            w_addr_o <= w_addr_o + 1'b1;
            cnt      <= cnt - 1'b1;
          end
        end
        DRAIN: begin
          if (dcnt == '0) begin
            pu_done_o <= 1'b1;
            state     <= LATCH;
          end else begin
            dcnt <= dcnt - 1'b1;
          end
        end
        LATCH: begin
          pu_en_o     <= 1'b0;
          out_valid_o <= 1'b1;
          state       <= OUT;
        end
        OUT: begin
          // busy_o stays high through the done_o cycle; IDLE clears it next edge.
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            done_o      <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
